// File: rtl/util_io_loop_check.sv
// util_io_loop_check: compares loop-back io_state samples against a FIFO of
// launched io_expect words; keeps counters, sticky flags and first-error capture.
module util_io_loop_check #(
    parameter int IO_WIDTH  = 8,
    parameter int DEPTH     = 16,
    parameter int CNT_WIDTH = 32,
    localparam int AW       = $clog2(DEPTH),
    localparam int LW       = AW + 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 enable,
    input  logic                 clear,
    input  logic [IO_WIDTH-1:0]  bit_mask,
    input  logic [IO_WIDTH-1:0]  io_expect,
    input  logic                 io_expect_valid,
    input  logic [IO_WIDTH-1:0]  io_state,
    input  logic                 io_state_valid,
    output logic                 cmp_error,
    output logic                 cmp_error_valid,
    output logic [CNT_WIDTH-1:0] sample_cnt,
    output logic [CNT_WIDTH-1:0] error_cnt,
    output logic [IO_WIDTH-1:0]  err_bits,
    output logic                 first_err_valid,
    output logic [IO_WIDTH-1:0]  first_err_state,
    output logic [IO_WIDTH-1:0]  first_err_expect,
    output logic [LW-1:0]        fifo_level,
    output logic                 overflow,
    output logic                 underflow
);

    logic [IO_WIDTH-1:0]  r_mem [DEPTH];
    logic [AW-1:0]        r_wptr;
    logic [AW-1:0]        r_rptr;
    logic [LW-1:0]        r_level;
    logic                 r_cmp_error;
    logic                 r_cmp_valid;
    logic [CNT_WIDTH-1:0] r_sample_cnt;
    logic [CNT_WIDTH-1:0] r_error_cnt;
    logic [IO_WIDTH-1:0]  r_err_bits;
    logic                 r_first_valid;
    logic [IO_WIDTH-1:0]  r_first_state;
    logic [IO_WIDTH-1:0]  r_first_expect;
    logic                 r_overflow;
    logic                 r_underflow;

    logic                 w_empty;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_drop;
    logic                 w_under;
    logic [IO_WIDTH-1:0]  w_head;
    logic [IO_WIDTH-1:0]  w_diff;
    logic                 w_mis;

    // Empty is judged on the occupancy before this cycle: no push-to-pop bypass.
    always_comb begin
        w_empty = (r_level == '0);
        w_full  = (r_level == LW'(DEPTH));
        w_head  = r_mem[r_rptr];
        w_pop   = enable && io_state_valid && !w_empty;
        w_under = enable && io_state_valid && w_empty;
        w_push  = enable && io_expect_valid && (!w_full || w_pop);
        w_drop  = enable && io_expect_valid && !w_push;
        w_diff  = (io_state ^ w_head) & bit_mask;
        w_mis   = |w_diff;
    end

    always_ff @(posedge clk) begin
        if (!rstn || clear) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wptr         <= '0;
            r_rptr         <= '0;
            r_level        <= '0;
            r_cmp_error    <= 1'b0;
            r_cmp_valid    <= 1'b0;
            r_sample_cnt   <= '0;
            r_error_cnt    <= '0;
            r_err_bits     <= '0;
            r_first_valid  <= 1'b0;
            r_first_state  <= '0;
            r_first_expect <= '0;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
        end else if (!enable) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_level     <= '0;
            r_cmp_valid <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= io_expect;
                r_wptr        <= r_wptr + AW'(1);
            end
            if (w_pop) r_rptr <= r_rptr + AW'(1);
            r_level     <= r_level + LW'(w_push) - LW'(w_pop);
            r_cmp_valid <= w_pop;
            if (w_pop) begin
                r_cmp_error <= w_mis;
                r_err_bits  <= r_err_bits | w_diff;
                if (r_sample_cnt != '1)
                    r_sample_cnt <= r_sample_cnt + CNT_WIDTH'(1);
                if (w_mis && r_error_cnt != '1)
                    r_error_cnt <= r_error_cnt + CNT_WIDTH'(1);
                if (w_mis && !r_first_valid) begin
                    r_first_valid  <= 1'b1;
                    r_first_state  <= io_state;
                    r_first_expect <= w_head;
                end
            end
            if (w_drop)  r_overflow  <= 1'b1;
            if (w_under) r_underflow <= 1'b1;
        end
    end

    assign cmp_error        = r_cmp_error;
    assign cmp_error_valid  = r_cmp_valid;
    assign sample_cnt       = r_sample_cnt;
    assign error_cnt        = r_error_cnt;
    assign err_bits         = r_err_bits;
    assign first_err_valid  = r_first_valid;
    assign first_err_state  = r_first_state;
    assign first_err_expect = r_first_expect;
    assign fifo_level       = r_level;
    assign overflow         = r_overflow;
    assign underflow        = r_underflow;

endmodule

// File: tb/tb_util_io_loop_check.sv
// tb_util_io_loop_check: directed plan plus random traffic, checked against
// a queue-based reference model of the loop-back checker.
module tb_util_io_loop_check;

    localparam int IOW = 8;
    localparam int DEP = 16;
    localparam int CW  = 4;
    localparam int SAT = 15;

    logic           clk = 1'b0;
    logic           rstn, enable, clear;
    logic [IOW-1:0] bit_mask, io_expect, io_state;
    logic           io_expect_valid, io_state_valid;
    logic           cmp_error, cmp_error_valid;
    logic [CW-1:0]  sample_cnt, error_cnt;
    logic [IOW-1:0] err_bits, first_err_state, first_err_expect;
    logic           first_err_valid, overflow, underflow;
    logic [4:0]     fifo_level;

    util_io_loop_check #(.IO_WIDTH(IOW), .DEPTH(DEP), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rstn(rstn), .enable(enable), .clear(clear),
        .bit_mask(bit_mask), .io_expect(io_expect),
        .io_expect_valid(io_expect_valid), .io_state(io_state),
        .io_state_valid(io_state_valid), .cmp_error(cmp_error),
        .cmp_error_valid(cmp_error_valid), .sample_cnt(sample_cnt),
        .error_cnt(error_cnt), .err_bits(err_bits),
        .first_err_valid(first_err_valid),
        .first_err_state(first_err_state),
        .first_err_expect(first_err_expect), .fifo_level(fifo_level),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    int q[$];
    int m_samp, m_errc, m_bits, m_fs, m_fe;
    bit m_cv, m_ce, m_fv, m_ov, m_un;
    logic [7:0] cur_mask = 8'hFF;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model(input bit r, c, e, ev, input int ex,
                         input bit sv, input int st, input int mk);
        int h, d;
        if (!r || c) begin
            q.delete();
            {m_cv, m_ce, m_fv, m_ov, m_un} = '0;
            m_samp = 0; m_errc = 0; m_bits = 0; m_fs = 0; m_fe = 0;
        end else if (!e) begin
            q.delete();
            m_cv = 0;
        end else begin
            m_cv = sv && q.size() > 0;
            if (sv && q.size() == 0) m_un = 1;
            if (m_cv) begin
                h = q.pop_front();
                d = (st ^ h) & mk;
                m_ce = d != 0;
                m_samp = (m_samp < SAT) ? m_samp + 1 : SAT;
                if (m_ce) m_errc = (m_errc < SAT) ? m_errc + 1 : SAT;
                m_bits |= d;
                if (m_ce && !m_fv) begin
                    m_fv = 1; m_fs = st; m_fe = h;
                end
            end
            if (ev) begin
                if (q.size() < DEP) q.push_back(ex);
                else m_ov = 1;
            end
        end
    endtask

    task automatic check_all();
        chk("level", fifo_level, q.size());
        chk("cmp_vld", cmp_error_valid, m_cv);
        chk("cmp_err", cmp_error, m_ce);
        chk("samp", sample_cnt, m_samp);
        chk("errc", error_cnt, m_errc);
        chk("bits", err_bits, m_bits);
        chk("fvld", first_err_valid, m_fv);
        chk("fstate", first_err_state, m_fs);
        chk("fexp", first_err_expect, m_fe);
        chk("ovf", overflow, m_ov);
        chk("unf", underflow, m_un);
    endtask

    task automatic cyc(input bit r, c, e, ev, input logic [7:0] ex,
                       input bit sv, input logic [7:0] st);
        rstn = r; clear = c; enable = e;
        io_expect_valid = ev; io_expect = ex;
        io_state_valid = sv; io_state = st; bit_mask = cur_mask;
        @(posedge clk);
        model(r, c, e, ev, ex, sv, st, cur_mask);
        #1 check_all();
    endtask

    task automatic push(input logic [7:0] x);
        cyc(1, 0, 1, 1, x, 0, 8'h00);
    endtask
    task automatic pop(input logic [7:0] s);
        cyc(1, 0, 1, 0, 8'h00, 1, s);
    endtask
    task automatic pp(input logic [7:0] x, input logic [7:0] s);
        cyc(1, 0, 1, 1, x, 1, s);
    endtask
    task automatic clr();
        cyc(1, 1, 1, 0, 8'h00, 0, 8'h00);
    endtask

    initial begin
        bit r, c, e, ev, sv;
        logic [7:0] ex, st;
        int sel;

        cyc(0, 0, 0, 0, 8'h00, 0, 8'h00);
        chk("rst_samp", sample_cnt, 0);
        chk("rst_lvl", fifo_level, 0);

        push(8'h05); push(8'h06); push(8'h07);
        chk("m_lvl3", fifo_level, 3);
        for (int i = 0; i < 3; i++) begin
            pop(8'(5 + i));
            chk("m_strobe", cmp_error_valid, 1);
            chk("m_err", cmp_error, 0);
        end
        chk("m_samp", sample_cnt, 3);
        chk("m_errc", error_cnt, 0);
        chk("m_lvl0", fifo_level, 0);

        clr();
        push(8'h05); push(8'h10); pop(8'h04); pop(8'h30);
        chk("x_errc", error_cnt, 2);
        chk("x_bits", err_bits, 8'h21);
        chk("x_fs", first_err_state, 8'h04);
        chk("x_fe", first_err_expect, 8'h05);
        clr();
        cur_mask = 8'hFE;
        push(8'h05); pop(8'h04);
        chk("x_mask", cmp_error, 0);
        cur_mask = 8'hFF;

        clr();
        for (int i = 0; i < 17; i++) push(8'(i));
        chk("f_ovf", overflow, 1);
        chk("f_lvl", fifo_level, 16);
        clr();
        for (int i = 0; i < 16; i++) push(8'(i));
        pp(8'hAA, 8'h00);
        chk("f_pp_ovf", overflow, 0);
        chk("f_pp_lvl", fifo_level, 16);

        clr();
        pp(8'h33, 8'h33);
        chk("u_unf", underflow, 1);
        chk("u_strobe", cmp_error_valid, 0);
        chk("u_samp", sample_cnt, 0);
        chk("u_lvl", fifo_level, 1);

        clr();
        push(8'h00);
        for (int i = 0; i < 20; i++) pp(8'h00, 8'hFF);
        chk("s_samp", sample_cnt, 15);
        chk("s_errc", error_cnt, 15);

        clr();
        push(8'h01);
        cyc(1, 1, 1, 0, 8'h00, 1, 8'h01);
        chk("c_strobe", cmp_error_valid, 0);
        chk("c_lvl", fifo_level, 0);
        push(8'h03); pop(8'h03); push(8'h04); push(8'h05);
        cyc(1, 0, 0, 0, 8'h00, 0, 8'h00);
        chk("e_lvl", fifo_level, 0);
        chk("e_samp", sample_cnt, 1);
        push(8'h06); pop(8'h07); push(8'h08);
        cyc(0, 0, 1, 1, 8'h09, 1, 8'h08);
        chk("r_errc", error_cnt, 0);
        chk("r_lvl", fifo_level, 0);
        chk("r_fvld", first_err_valid, 0);

        for (int n = 0; n < 3000; n++) begin
            r  = $urandom_range(0, 199) != 0;
            c  = $urandom_range(0, 63) == 0;
            e  = $urandom_range(0, 15) != 0;
            ev = $urandom_range(0, 99) < 55;
            sv = $urandom_range(0, 99) < 50;
            ex = 8'($urandom);
            st = 8'($urandom);
            if (q.size() > 0 && $urandom_range(0, 1) == 1) st = 8'(q[0]);
            sel = $urandom_range(0, 9);
            cur_mask = (sel < 3) ? 8'hFF : (sel == 3) ? 8'h00 : 8'($urandom);
            cyc(r, c, e, ev, ex, sv, st);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
